// File: rtl/axi_10g_ethernet_0_arp_ctrl.sv
// ARP controller: 4-entry IP->MAC cache, next-hop lookup with request/timeout/retry,
// and arbitration of the shared ARP tx generator between replies and our own requests.
module axi_10g_ethernet_0_arp_ctrl #(
  parameter logic [31:0] BOARD_IP       = {8'd192, 8'd168, 8'd2, 8'd20},
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_562_500,
  parameter int          MAX_RETRY      = 3
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        rx_arp_req,
  input  logic        rx_arp_reply,
  input  logic [47:0] rx_src_mac,
  input  logic [31:0] rx_src_ip,
  input  logic [31:0] rx_dst_ip,
  input  logic        lookup_req,
  input  logic [31:0] lookup_ip,
  output logic        lookup_ready,
  output logic        lookup_done,
  output logic        lookup_hit,
  output logic [47:0] lookup_mac,
  output logic        arp_tx_start,
  output logic        arp_tx_op,
  output logic [47:0] arp_tx_dst_mac,
  output logic [31:0] arp_tx_dst_ip,
  input  logic        arp_tx_done
);

  localparam int          NENT    = 4;
  localparam logic [7:0]  MAXR    = 8'(MAX_RETRY);
  localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 32'd1;
  localparam logic [47:0] BCAST   = 48'hffff_ffff_ffff;

  typedef enum logic [1:0] {L_IDLE, L_CHK, L_WAIT, L_DONE} lstate_t;
  typedef enum logic {T_IDLE, T_BUSY} tstate_t;

  lstate_t l_q, l_d;
  tstate_t t_q, t_d;

  logic [NENT-1:0]        vld_q, vld_d;
  logic [NENT-1:0][31:0]  cip_q, cip_d;
  logic [NENT-1:0][47:0]  cmac_q, cmac_d;
  logic [1:0]             wptr_q, wptr_d;

  logic [31:0] lip_q, lip_d;
  logic        res_hit_q, res_hit_d;
  logic [47:0] res_mac_q, res_mac_d;
  logic [7:0]  retry_q, retry_d;
  logic [31:0] timer_q, timer_d;
  logic        req_pend_q, req_pend_d;
  logic        reply_pend_q, reply_pend_d;
  logic [47:0] rp_mac_q, rp_mac_d;
  logic [31:0] rp_ip_q, rp_ip_d;

  logic        start_q, start_d;
  logic        op_q, op_d;
  logic [47:0] dmac_q, dmac_d;
  logic [31:0] dip_q, dip_d;

  logic            rx_any, learn, reply_set, reply_match;
  logic [NENT-1:0] hit_rx, hit_lk;
  logic            chk_hit;
  logic [47:0]     chk_mac;
  logic            chk_miss, req_retry, lk_end;
  logic            issue_reply, issue_req;

  assign rx_any      = (rx_arp_req || rx_arp_reply) && (rx_src_ip != 32'd0);
  assign learn       = rx_any;
  assign reply_set   = rx_any && rx_arp_req && (rx_dst_ip == BOARD_IP);
  assign reply_match = rx_any && rx_arp_reply && (rx_src_ip == lip_q);

  for (genvar i = 0; i < NENT; i++) begin : g_ent
    assign hit_rx[i] = vld_q[i] && (cip_q[i] == rx_src_ip);
    assign hit_lk[i] = vld_q[i] && (cip_q[i] == lip_q);
  end

  // Learning: refresh in place if the IP is known, else FIFO-replace at wptr.
  always_comb begin
    vld_d  = vld_q;
    cip_d  = cip_q;
    cmac_d = cmac_q;
    wptr_d = wptr_q;
    if (learn) begin
      if (|hit_rx) begin
        for (int i = 0; i < NENT; i++)
          if (hit_rx[i]) cmac_d[i] = rx_src_mac;
      end else begin
        vld_d[wptr_q]  = 1'b1;
        cip_d[wptr_q]  = rx_src_ip;
        cmac_d[wptr_q] = rx_src_mac;
        wptr_d         = wptr_q + 2'd1;
      end
    end
  end

  always_comb begin
    chk_hit = 1'b0;
    chk_mac = 48'd0;
    for (int i = 0; i < NENT; i++)
      if (hit_lk[i]) begin
        chk_hit = 1'b1;
        chk_mac = cmac_q[i];
      end
  end

  // Lookup FSM
  always_comb begin
    l_d       = l_q;
    lip_d     = lip_q;
    res_hit_d = res_hit_q;
    res_mac_d = res_mac_q;
    retry_d   = retry_q;
    chk_miss  = 1'b0;
    req_retry = 1'b0;
    case (l_q)
      L_IDLE: if (lookup_req) begin
        lip_d = lookup_ip;
        l_d   = L_CHK;
      end
      L_CHK: begin
        if (chk_hit) begin
          res_hit_d = 1'b1;
          res_mac_d = chk_mac;
          l_d       = L_DONE;
        end else begin
          chk_miss = 1'b1;
          retry_d  = 8'd0;
          l_d      = L_WAIT;
        end
      end
      L_WAIT: begin
        if (reply_match) begin
          res_hit_d = 1'b1;
          res_mac_d = rx_src_mac;
          l_d       = L_DONE;
        end else if (!req_pend_q && timer_q == TO_LAST) begin
          if (retry_q < MAXR) begin
            retry_d   = retry_q + 8'd1;
            req_retry = 1'b1;
          end else begin
            res_hit_d = 1'b0;
            res_mac_d = 48'd0;
            l_d       = L_DONE;
          end
        end
      end
      L_DONE: begin
        res_hit_d = 1'b0;
        res_mac_d = 48'd0;
        l_d       = L_IDLE;
      end
      default: l_d = L_IDLE;
    endcase
  end

  assign lk_end = (l_q == L_WAIT) && (l_d == L_DONE);

  // Tx arbiter: a done in T_BUSY can launch the next frame directly, so
  // back-to-back transactions start the cycle after the generator finishes.
  always_comb begin
    t_d         = t_q;
    start_d     = 1'b0;
    op_d        = op_q;
    dmac_d      = dmac_q;
    dip_d       = dip_q;
    issue_reply = 1'b0;
    issue_req   = 1'b0;
    if (t_q == T_IDLE || arp_tx_done) begin
      if (reply_set || reply_pend_q) begin
        issue_reply = 1'b1;
        t_d         = T_BUSY;
        start_d     = 1'b1;
        op_d        = 1'b1;
        dmac_d      = reply_set ? rx_src_mac : rp_mac_q;
        dip_d       = reply_set ? rx_src_ip  : rp_ip_q;
      end else if (req_pend_q || req_retry) begin
        issue_req = 1'b1;
        t_d       = T_BUSY;
        start_d   = 1'b1;
        op_d      = 1'b0;
        dmac_d    = BCAST;
        dip_d     = lip_q;
      end else begin
        t_d    = T_IDLE;
        op_d   = 1'b0;
        dmac_d = 48'd0;
        dip_d  = 32'd0;
      end
    end
  end

  // Timer runs from each request launch; it freezes while a retry waits behind a reply.
  always_comb begin
    reply_pend_d = (reply_pend_q || reply_set) && !issue_reply;
    rp_mac_d     = reply_set ? rx_src_mac : rp_mac_q;
    rp_ip_d      = reply_set ? rx_src_ip  : rp_ip_q;
    req_pend_d   = (req_pend_q || chk_miss || req_retry) && !issue_req && !lk_end;
    timer_d      = timer_q;
    if (issue_req || req_retry || l_q == L_CHK)
      timer_d = 32'd0;
    else if (l_q == L_WAIT && !req_pend_q)
      timer_d = timer_q + 32'd1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      l_q          <= L_IDLE;
      t_q          <= T_IDLE;
      vld_q        <= '0;
      wptr_q       <= 2'd0;
      lip_q        <= 32'd0;
      res_hit_q    <= 1'b0;
      res_mac_q    <= 48'd0;
      retry_q      <= 8'd0;
      timer_q      <= 32'd0;
      req_pend_q   <= 1'b0;
      reply_pend_q <= 1'b0;
      rp_mac_q     <= 48'd0;
      rp_ip_q      <= 32'd0;
      start_q      <= 1'b0;
      op_q         <= 1'b0;
      dmac_q       <= 48'd0;
      dip_q        <= 32'd0;
    end else begin
      l_q          <= l_d;
      t_q          <= t_d;
      vld_q        <= vld_d;
      wptr_q       <= wptr_d;
      lip_q        <= lip_d;
      res_hit_q    <= res_hit_d;
      res_mac_q    <= res_mac_d;
      retry_q      <= retry_d;
      timer_q      <= timer_d;
      req_pend_q   <= req_pend_d;
      reply_pend_q <= reply_pend_d;
      rp_mac_q     <= rp_mac_d;
      rp_ip_q      <= rp_ip_d;
      start_q      <= start_d;
      op_q         <= op_d;
      dmac_q       <= dmac_d;
      dip_q        <= dip_d;
    end
  end

  always_ff @(posedge aclk) begin
    cip_q  <= cip_d;
    cmac_q <= cmac_d;
  end

  assign lookup_ready   = (l_q == L_IDLE);
  assign lookup_done    = (l_q == L_DONE);
  assign lookup_hit     = lookup_done && res_hit_q;
  assign lookup_mac     = (lookup_done && res_hit_q) ? res_mac_q : 48'd0;
  assign arp_tx_start   = start_q;
  assign arp_tx_op      = op_q;
  assign arp_tx_dst_mac = dmac_q;
  assign arp_tx_dst_ip  = dip_q;

endmodule

// File: tb/tb_axi_10g_ethernet_0_arp_ctrl.sv
// Scoreboard bench for the ARP controller: expected lookup results and tx starts are
// queued by the stimulus and checked by an independent monitor, with exact cycle stamps.
module tb_axi_10g_ethernet_0_arp_ctrl;

  localparam logic [31:0] BIP   = {8'd192, 8'd168, 8'd2, 8'd20};
  localparam logic [47:0] BCAST = 48'hffff_ffff_ffff;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        rx_arp_req = 1'b0, rx_arp_reply = 1'b0;
  logic [47:0] rx_src_mac = '0;
  logic [31:0] rx_src_ip = '0, rx_dst_ip = '0;
  logic        lookup_req = 1'b0;
  logic [31:0] lookup_ip = '0;
  logic        lookup_ready, lookup_done, lookup_hit;
  logic [47:0] lookup_mac;
  logic        arp_tx_start, arp_tx_op;
  logic [47:0] arp_tx_dst_mac;
  logic [31:0] arp_tx_dst_ip;
  logic        arp_tx_done = 1'b0;

  axi_10g_ethernet_0_arp_ctrl #(
    .BOARD_IP(BIP), .TIMEOUT_CYCLES(32'd100), .MAX_RETRY(3)
  ) dut (
    .aclk(aclk), .areset(areset),
    .rx_arp_req(rx_arp_req), .rx_arp_reply(rx_arp_reply),
    .rx_src_mac(rx_src_mac), .rx_src_ip(rx_src_ip), .rx_dst_ip(rx_dst_ip),
    .lookup_req(lookup_req), .lookup_ip(lookup_ip), .lookup_ready(lookup_ready),
    .lookup_done(lookup_done), .lookup_hit(lookup_hit), .lookup_mac(lookup_mac),
    .arp_tx_start(arp_tx_start), .arp_tx_op(arp_tx_op),
    .arp_tx_dst_mac(arp_tx_dst_mac), .arp_tx_dst_ip(arp_tx_dst_ip),
    .arp_tx_done(arp_tx_done)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct { logic hit; logic [47:0] mac; int cyc; } lk_exp_t;
  typedef struct { logic op; logic [47:0] mac; logic [31:0] ip; int cyc; } tx_exp_t;
  lk_exp_t lkq[$];
  tx_exp_t txq[$];
  int tests = 0, fails = 0;

  // Monitor: every DUT output event is matched against the head of its queue.
  always @(negedge aclk) begin
    lk_exp_t le;
    tx_exp_t te;
    if (!areset) begin
      if (lookup_done) begin
        tests++;
        if (lkq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_lookup_done cyc=%0d hit=%0b mac=%h", cyc, lookup_hit, lookup_mac);
        end else begin
          le = lkq.pop_front();
          if (lookup_hit !== le.hit || lookup_mac !== le.mac || cyc != le.cyc) begin
            fails++;
            $display("FAIL lookup_result got hit=%0b mac=%h cyc=%0d exp hit=%0b mac=%h cyc=%0d",
                     lookup_hit, lookup_mac, cyc, le.hit, le.mac, le.cyc);
          end
        end
      end
      if (arp_tx_start) begin
        tests++;
        if (txq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_tx_start cyc=%0d op=%0b mac=%h ip=%h", cyc, arp_tx_op, arp_tx_dst_mac, arp_tx_dst_ip);
        end else begin
          te = txq.pop_front();
          if (arp_tx_op !== te.op || arp_tx_dst_mac !== te.mac || arp_tx_dst_ip !== te.ip || cyc != te.cyc) begin
            fails++;
            $display("FAIL tx_start got op=%0b mac=%h ip=%h cyc=%0d exp op=%0b mac=%h ip=%h cyc=%0d",
                     arp_tx_op, arp_tx_dst_mac, arp_tx_dst_ip, cyc, te.op, te.mac, te.ip, te.cyc);
          end
        end
      end
    end
  end

  // Generator model: finishes each frame 3 cycles after its start.
  initial begin
    forever begin
      @(negedge aclk);
      if (arp_tx_start && !areset) begin
        repeat (3) @(posedge aclk);
        #1 arp_tx_done = 1'b1;
        @(posedge aclk);
        #1 arp_tx_done = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic lookup(input logic [31:0] ip, output int n);
    tick();
    lookup_req = 1'b1;
    lookup_ip  = ip;
    n = cyc;
    tick();
    lookup_req = 1'b0;
  endtask

  task automatic rx(input logic req, input logic rep, input logic [47:0] mac,
                    input logic [31:0] sip, input logic [31:0] dip, output int c);
    tick();
    rx_arp_req = req; rx_arp_reply = rep;
    rx_src_mac = mac; rx_src_ip = sip; rx_dst_ip = dip;
    c = cyc;
    tick();
    rx_arp_req = 1'b0; rx_arp_reply = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int max);
    int i = 0;
    while ((lkq.size() != 0 || txq.size() != 0) && i < max) begin
      tick();
      i++;
    end
    tests++;
    if (lkq.size() != 0 || txq.size() != 0) begin
      fails++;
      $display("FAIL %s outstanding lk=%0d tx=%0d exp lk=0 tx=0", nm, lkq.size(), txq.size());
    end
    lkq.delete();
    txq.delete();
    repeat (6) tick();
  endtask

  task automatic do_reset(input string nm);
    tick();
    areset = 1'b1;
    tick();
    tick();
    lkq.delete();
    txq.delete();
    check({nm, "_ready"}, 128'(lookup_ready), 128'(1'b1));
    check({nm, "_lk"}, 128'({lookup_done, lookup_hit, lookup_mac}), 128'(0));
    check({nm, "_tx"}, 128'({arp_tx_start, arp_tx_op, arp_tx_dst_mac, arp_tx_dst_ip}), 128'(0));
    areset = 1'b0;
    tick();
    check({nm, "_post"}, 128'({lookup_ready, lookup_done, arp_tx_start, arp_tx_dst_ip}), 128'({1'b1, 34'd0}));
  endtask

  initial begin
    int n, r, s;
    do_reset("reset");

    // Hit path
    rx(1'b0, 1'b1, 48'h0A0B0C0D0E0F, 32'hC0A80215, BIP, r);
    lookup(32'hC0A80215, n);
    lkq.push_back('{1'b1, 48'h0A0B0C0D0E0F, n + 2});
    wait_done("hit", 20);

    // Miss then resolve
    lookup(32'hC0A80216, n);
    txq.push_back('{1'b0, BCAST, 32'hC0A80216, n + 3});
    repeat (45) tick();
    rx(1'b0, 1'b1, 48'h112233445566, 32'hC0A80216, BIP, r);
    lkq.push_back('{1'b1, 48'h112233445566, r + 1});
    wait_done("miss_resolve", 20);

    // Timeout exhaustion: 4 requests 100 cycles apart, then a failed lookup
    lookup(32'hC0A80217, n);
    s = n + 3;
    for (int k = 0; k < 4; k++) txq.push_back('{1'b0, BCAST, 32'hC0A80217, s + 100 * k});
    lkq.push_back('{1'b0, 48'd0, s + 400});
    wait_done("timeout", 500);

    // Arbitration: reply for us arrives in the cycle the miss sets req_pend
    tick();
    lookup_req = 1'b1; lookup_ip = 32'hC0A80218; n = cyc;
    tick();
    lookup_req = 1'b0;
    rx_arp_req = 1'b1; rx_src_mac = 48'h00AABBCCDDEE; rx_src_ip = 32'hC0A80230; rx_dst_ip = BIP;
    tick();
    rx_arp_req = 1'b0;
    txq.push_back('{1'b1, 48'h00AABBCCDDEE, 32'hC0A80230, n + 2});
    txq.push_back('{1'b0, BCAST, 32'hC0A80218, n + 6});
    repeat (10) tick();
    rx(1'b0, 1'b1, 48'h0000DEADBEEF, 32'hC0A80218, BIP, r);
    lkq.push_back('{1'b1, 48'h0000DEADBEEF, r + 1});
    wait_done("arbitration", 30);

    // Non-local request: no reply, sender still learned
    rx(1'b1, 1'b0, 48'h000044445555, 32'hC0A80240, 32'hC0A80299, r);
    repeat (8) tick();
    lookup(32'hC0A80240, n);
    lkq.push_back('{1'b1, 48'h000044445555, n + 2});
    wait_done("nonlocal", 20);

    // FIFO replacement: 5 new IPs evict the first of them
    for (int k = 1; k <= 5; k++) begin
      rx(1'b0, 1'b1, 48'h00000000A000 + 48'(k), 32'hC0A80250 + 32'(k), BIP, r);
    end
    lookup(32'hC0A80255, n);
    lkq.push_back('{1'b1, 48'h00000000A005, n + 2});
    wait_done("repl_hit5", 20);
    lookup(32'hC0A80251, n);
    txq.push_back('{1'b0, BCAST, 32'hC0A80251, n + 3});
    wait_done("repl_miss1", 20);
    do_reset("reset_wait");

    // After reset the cache is empty
    lookup(32'hC0A80255, n);
    txq.push_back('{1'b0, BCAST, 32'hC0A80255, n + 3});
    wait_done("post_rst_miss_a", 20);
    do_reset("reset_b");
    lookup(32'hC0A80240, n);
    txq.push_back('{1'b0, BCAST, 32'hC0A80240, n + 3});
    wait_done("post_rst_miss_b", 20);
    do_reset("reset_c");
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
